// File: rtl/bp_cfg_loader.sv
// Config-link sequencing master: per core, freezes it, loads CCE microcode from a
// 1-cycle ROM in uncached mode, switches to normal mode and unfreezes.
module bp_cfg_loader #(
  parameter int num_core_p              = 1,
  parameter int cfg_core_width_p        = 8,
  parameter int cfg_addr_width_p        = 16,
  parameter int cfg_data_width_p        = 32,
  parameter int num_cce_instr_ram_els_p = 256,
  parameter int ucode_width_p           = 64,
  localparam int entry_width_lp = (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        cfg_w_v_o,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  output logic                        ucode_v_o,
  output logic [entry_width_lp-1:0]   ucode_addr_o,
  input  logic [ucode_width_p-1:0]    ucode_data_i
);

  localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE  = cfg_addr_width_p'(16'h0001);
  localparam logic [cfg_addr_width_p-1:0] ADDR_MODE    = cfg_addr_width_p'(16'h0002);
  localparam logic [cfg_addr_width_p-1:0] ADDR_UC_BASE = cfg_addr_width_p'(16'h8000);
  localparam logic [cfg_data_width_p-1:0] DATA_ZERO    = {cfg_data_width_p{1'b0}};
  localparam logic [cfg_data_width_p-1:0] DATA_ONE     = cfg_data_width_p'(1'b1);

  typedef enum logic [3:0] {
    S_IDLE, S_FREEZE, S_MODE_UC, S_FETCH, S_LATCH,
    S_UC_LO, S_UC_HI, S_MODE_NORM, S_UNFREEZE, S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [cfg_core_width_p-1:0] r_core;
  logic [entry_width_lp-1:0]   r_entry;
  logic [ucode_width_p-1:0]    r_hold;
  logic [cfg_addr_width_p-1:0] w_uc_addr;
  logic                        w_start;
  logic                        w_accept;
  logic                        w_core_last;
  logic                        w_entry_last;

  assign w_start      = start_i & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_accept     = cfg_w_v_o & cfg_ready_i;
  assign w_core_last  = (r_core == cfg_core_width_p'(num_core_p - 1));
  assign w_entry_last = (r_entry == entry_width_lp'(num_cce_instr_ram_els_p - 1));
  assign w_uc_addr    = ADDR_UC_BASE + cfg_addr_width_p'({r_entry, 1'b0});

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_next = start_i ? S_FREEZE : r_state;
      S_FREEZE:       w_state_next = w_accept ? S_MODE_UC : S_FREEZE;
      S_MODE_UC:      w_state_next = w_accept ? S_FETCH : S_MODE_UC;
      S_FETCH:        w_state_next = S_LATCH;
      S_LATCH:        w_state_next = S_UC_LO;
      S_UC_LO:        w_state_next = w_accept ? S_UC_HI : S_UC_LO;
      S_UC_HI:        w_state_next = !w_accept ? S_UC_HI : (w_entry_last ? S_MODE_NORM : S_FETCH);
      S_MODE_NORM:    w_state_next = w_accept ? S_UNFREEZE : S_MODE_NORM;
      S_UNFREEZE:     w_state_next = !w_accept ? S_UNFREEZE : (w_core_last ? S_DONE : S_FREEZE);
      default:        w_state_next = S_IDLE;
    endcase
  end

  // Holding register only loads in LATCH, so it is stable across stalled UC_LO/UC_HI writes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_core  <= {cfg_core_width_p{1'b0}};
      r_entry <= {entry_width_lp{1'b0}};
      r_hold  <= {ucode_width_p{1'b0}};
    end else if (w_start) begin
      r_core  <= {cfg_core_width_p{1'b0}};
      r_entry <= {entry_width_lp{1'b0}};
    end else begin
      if (r_state == S_LATCH)
        r_hold <= ucode_data_i;
      if ((r_state == S_UC_HI) && w_accept)
        r_entry <= w_entry_last ? {entry_width_lp{1'b0}} : r_entry + entry_width_lp'(1);
      if ((r_state == S_UNFREEZE) && w_accept && !w_core_last)
        r_core <= r_core + cfg_core_width_p'(1);
    end
  end

  always_comb begin
    cfg_w_v_o    = 1'b0;
    cfg_addr_o   = {cfg_addr_width_p{1'b0}};
    cfg_data_o   = DATA_ZERO;
    ucode_v_o    = 1'b0;
    ucode_addr_o = {entry_width_lp{1'b0}};
    case (r_state)
      S_FREEZE:    begin cfg_w_v_o = 1'b1; cfg_addr_o = ADDR_FREEZE; cfg_data_o = DATA_ONE;  end
      S_MODE_UC:   begin cfg_w_v_o = 1'b1; cfg_addr_o = ADDR_MODE;   cfg_data_o = DATA_ZERO; end
      S_FETCH:     begin ucode_v_o = 1'b1; ucode_addr_o = r_entry; end
      S_UC_LO:     begin
        cfg_w_v_o  = 1'b1;
        cfg_addr_o = w_uc_addr;
        cfg_data_o = r_hold[cfg_data_width_p-1:0];
      end
      S_UC_HI:     begin
        cfg_w_v_o  = 1'b1;
        cfg_addr_o = w_uc_addr + cfg_addr_width_p'(1);
        cfg_data_o = r_hold[ucode_width_p-1:cfg_data_width_p];
      end
      S_MODE_NORM: begin cfg_w_v_o = 1'b1; cfg_addr_o = ADDR_MODE;   cfg_data_o = DATA_ONE;  end
      S_UNFREEZE:  begin cfg_w_v_o = 1'b1; cfg_addr_o = ADDR_FREEZE; cfg_data_o = DATA_ZERO; end
      default:     begin cfg_w_v_o = 1'b0; end
    endcase
    cfg_core_o = cfg_w_v_o ? r_core : {cfg_core_width_p{1'b0}};
    busy_o     = (r_state != S_IDLE) && (r_state != S_DONE);
    done_o     = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Randomized self-checking bench for bp_cfg_loader: two instances (3 cores x 2 entries,
// 1 core x 256 entries) against a write-list reference model.
module tb_bp_cfg_loader;

  localparam int CA = 3;
  localparam int NA = 2;
  localparam int NC = 256;

  typedef logic [55:0] wr_t;  // {core[7:0], addr[15:0], data[31:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, rdy_a, busy_a, done_a, v_a, uv_a;
  logic [7:0]  core_a;
  logic [15:0] addr_a;
  logic [31:0] data_a;
  logic [0:0]  ua_a;
  logic [63:0] rom_q_a;

  logic        rst_c, start_c, rdy_c, busy_c, done_c, v_c, uv_c;
  logic [7:0]  core_c;
  logic [15:0] addr_c;
  logic [31:0] data_c;
  logic [7:0]  ua_c;
  logic [63:0] rom_q_c;

  logic [63:0] rom [256];
  int checks = 0;
  int errors = 0;

  bp_cfg_loader #(.num_core_p(CA), .num_cce_instr_ram_els_p(NA)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .cfg_w_v_o(v_a), .cfg_core_o(core_a), .cfg_addr_o(addr_a), .cfg_data_o(data_a),
    .cfg_ready_i(rdy_a), .ucode_v_o(uv_a), .ucode_addr_o(ua_a), .ucode_data_i(rom_q_a)
  );

  bp_cfg_loader #(.num_core_p(1), .num_cce_instr_ram_els_p(NC)) dut_c (
    .clk_i(clk), .reset_i(rst_c), .start_i(start_c), .busy_o(busy_c), .done_o(done_c),
    .cfg_w_v_o(v_c), .cfg_core_o(core_c), .cfg_addr_o(addr_c), .cfg_data_o(data_c),
    .cfg_ready_i(rdy_c), .ucode_v_o(uv_c), .ucode_addr_o(ua_c), .ucode_data_i(rom_q_c)
  );

  // Synchronous 1-cycle ROMs.
  always @(posedge clk) begin
    if (uv_a) rom_q_a <= rom[{7'd0, ua_a}];
    if (uv_c) rom_q_c <= rom[ua_c];
  end

  wr_t got_a[$];
  wr_t got_c[$];
  wr_t prev_a;
  logic stalled_a = 1'b0;
  int stall_bad_a = 0;
  int ucv_bad_a   = 0;
  int umax_c      = 0;

  // Transfers are recorded on the falling edge ahead of the accepting rising edge.
  always @(negedge clk) begin
    if (rst_a) begin
      stalled_a <= 1'b0;
    end else begin
      if (stalled_a && !(v_a && ({core_a, addr_a, data_a} == prev_a))) stall_bad_a <= stall_bad_a + 1;
      if (v_a && uv_a) ucv_bad_a <= ucv_bad_a + 1;
      if (v_a && rdy_a) got_a.push_back({core_a, addr_a, data_a});
      stalled_a <= v_a && !rdy_a;
      prev_a    <= {core_a, addr_a, data_a};
    end
    if (!rst_c) begin
      if (v_c && rdy_c) got_c.push_back({core_c, addr_c, data_c});
      if (uv_c && (int'(ua_c) > umax_c)) umax_c <= int'(ua_c);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the ordered list of writes the whole boot sequence must produce.
  task automatic build(input int ncore, input int n, output wr_t q[$]);
    q = {};
    for (int c = 0; c < ncore; c++) begin
      q.push_back({8'(c), 16'h0001, 32'd1});
      q.push_back({8'(c), 16'h0002, 32'd0});
      for (int i = 0; i < n; i++) begin
        q.push_back({8'(c), 16'(32'h8000 + 2 * i),     rom[i][31:0]});
        q.push_back({8'(c), 16'(32'h8000 + 2 * i + 1), rom[i][63:32]});
      end
      q.push_back({8'(c), 16'h0002, 32'd1});
      q.push_back({8'(c), 16'h0001, 32'd0});
    end
  endtask

  task automatic cmp_run(input string tag, input wr_t exp[$], input wr_t got[$], input int base);
    chk({tag, "_count"}, 64'(got.size() - base), 64'(exp.size()));
    for (int k = 0; k < exp.size(); k++)
      if (base + k < got.size()) chk(tag, 64'(got[base + k]), 64'(exp[k]));
  endtask

  wr_t exp_q[$];
  int  cyc;
  int  base;
  bit  found;

  initial begin
    rst_a = 1'b1; rst_c = 1'b1; start_a = 1'b0; start_c = 1'b0; rdy_a = 1'b1; rdy_c = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = {$urandom, $urandom};
    rom[0] = 64'h11112222_33334444;
    rom[1] = 64'h55556666_77778888;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs_a", {busy_a, done_a, v_a, core_a, addr_a, data_a, uv_a, ua_a}, 64'd0);
    chk("reset_outs_c", {busy_c, done_c, v_c, core_c, addr_c, data_c, uv_c, ua_c}, 64'd0);
    rst_a = 1'b0; rst_c = 1'b0;
    @(posedge clk); #1;

    // Ready tied high: best-case timing and exact write order.
    build(CA, NA, exp_q);
    base = got_a.size();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    chk("done_latency_a", cyc, 36);
    chk("done_state_a", {done_a, busy_a}, 2'b10);
    cmp_run("seq_ready1", exp_q, got_a, base);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold_a", done_a, 1'b1);

    // Random ready with start pulses while busy: same sequence, stable stalled payload.
    base = got_a.size();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 3000) begin
      rdy_a   = ($urandom_range(0, 9) < 3);
      start_a = busy_a && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    start_a = 1'b0; rdy_a = 1'b1;
    chk("done_rand_a", done_a, 1'b1);
    cmp_run("seq_rand", exp_q, got_a, base);
    chk("stall_hold", stall_bad_a, 0);
    chk("ucode_v_in_write", ucv_bad_a, 0);

    // Start in DONE restarts immediately with core 0 freeze.
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("restart_from_done", {done_a, busy_a, v_a, core_a, addr_a, data_a}, {1'b0, 1'b1, 1'b1, 8'd0, 16'h0001, 32'd1});

    // Stall UC_HI of core 1 entry 1, then reset asynchronously between edges.
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 3000) begin
      if (v_a && core_a == 8'd1 && addr_a == 16'h8003) begin
        found = 1'b1;
        rdy_a = 1'b0;
      end else begin
        rdy_a = ($urandom_range(0, 9) < 3);
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("reach_uc_hi_c1", found, 1'b1);
    #2;
    rst_a = 1'b1;
    #1;
    chk("async_reset_outs", {busy_a, done_a, v_a, core_a, addr_a, data_a, uv_a, ua_a}, 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rdy_a = 1'b1;
    @(posedge clk); #1;

    // Replay after reset starts again at core 0, entry 0.
    base = got_a.size();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    chk("done_latency_replay", cyc, 36);
    cmp_run("seq_replay", exp_q, got_a, base);

    // Full-size microcode on a single core.
    build(1, NC, exp_q);
    base = got_c.size();
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    cyc = 0;
    while (!done_c && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    chk("done_latency_c", cyc, 1028);
    cmp_run("seq_c", exp_q, got_c, base);
    chk("ucode_addr_max_c", umax_c, 255);
    chk("last_uc_addr_c", (got_c.size() > 2) ? got_c[got_c.size() - 3][47:32] : 16'h0000, 16'h81FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_cfg_loader.md
# bp_cfg_loader

Sequencing master for the per-core configuration link: after `start_i` it walks every core and issues, in fixed order, the freeze, CCE-mode and CCE microcode writes needed to bring each core out of reset. It is the transmitting end of the config bus (`cfg_core`/`cfg_addr`/`cfg_data` widths from the processor config) and sits between the host/boot logic and the config-link receivers in each tile. Microcode is fetched from a synchronous 1-cycle-latency ROM.

## Interface
- `num_core_p`, default 1: cores to configure; core ids `0..num_core_p-1`.
- `cfg_core_width_p`, default 8: core-id field width.
- `cfg_addr_width_p`, default 16: config address width.
- `cfg_data_width_p`, default 32: config data width.
- `num_cce_instr_ram_els_p`, default 256: microcode entries per core (N).
- `ucode_width_p`, default 64: ROM word width; must equal `2*cfg_data_width_p`.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: reset; one clock, asynchronous, active-high.
- `start_i` in 1: begin the sequence; sampled only in IDLE or DONE.
- `busy_o` out 1: high in every state except IDLE and DONE.
- `done_o` out 1: high in DONE, held until the next accepted `start_i` or reset.
- `cfg_w_v_o` out 1: write valid.
- `cfg_core_o` out `cfg_core_width_p`: target core id.
- `cfg_addr_o` out `cfg_addr_width_p`: config address.
- `cfg_data_o` out `cfg_data_width_p`: config data.
- `cfg_ready_i` in 1: receiver ready.
- `ucode_v_o` out 1: ROM read enable.
- `ucode_addr_o` out `clog2(N)`: ROM index.
- `ucode_data_i` in `ucode_width_p`: ROM data, valid the cycle after `ucode_v_o`.

## Operation
- Fixed addresses:
  - `0x0001` freeze (data 1 = frozen, 0 = run).
  - `0x0002` CCE mode (0 = uncached, 1 = normal).
  - `0x8000 + 2i` microcode low word of entry i.
  - `0x8000 + 2i + 1` microcode high word of entry i.
- FSM states: IDLE, FREEZE, MODE_UC, FETCH, LATCH, UC_LO, UC_HI, MODE_NORM, UNFREEZE, DONE.
- IDLE/DONE with `start_i` → FREEZE; core counter and entry counter are cleared.
- FREEZE → MODE_UC → FETCH, each advancing on write accept.
- FETCH (one cycle): `ucode_v_o`=1, `ucode_addr_o`=i → LATCH.
- LATCH (one cycle): capture `ucode_data_i` into a holding register → UC_LO.
- UC_LO writes holding[31:0]; UC_HI writes holding[63:32]. Each advances on accept.
- After UC_HI accept: if i<N-1, i++ → FETCH; else i=0 → MODE_NORM.
- MODE_NORM → UNFREEZE. On UNFREEZE accept: if core<`num_core_p`-1, core++ → FREEZE; else → DONE.
- Writes per core: 4+2N, strictly in the order above. The holding register is not reloaded while a UC_LO/UC_HI write is pending.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, holding register 0.
- A write transfers on a cycle where `cfg_w_v_o` and `cfg_ready_i` are both high.
- `cfg_w_v_o` is high in FREEZE, MODE_UC, UC_LO, UC_HI, MODE_NORM and UNFREEZE, and never depends combinationally on `cfg_ready_i`.
- While valid and not ready, `cfg_core_o`/`cfg_addr_o`/`cfg_data_o` hold stable.
- Outside write states, `cfg_w_v_o`=0 and the payload is 0.
- Best case (ready tied 1): one cycle per state. Per-core cycles = 4+4N; N=256 gives 1028.
- `done_o` rises the cycle after the final UNFREEZE accept.
- `start_i` while busy is ignored. `start_i` in DONE restarts the full sequence: `done_o` drops and `busy_o` rises in the next cycle.
- `ucode_v_o` is high only in FETCH; it is never asserted while a write is pending.
- Counters: the entry counter wraps N-1→0 only on the MODE_NORM transition. The core counter never exceeds `num_core_p`-1.
- Reset asserted mid-sequence (any state) immediately forces all outputs to 0 and the state to IDLE. A subsequent start replays from core 0, entry 0.

## Test plan
- N=2, num_core=1, ready=1, ROM {0x11112222_33334444, 0x55556666_77778888} → eight writes in order: (0x0001,1), (0x0002,0), (0x8000,0x33334444), (0x8001,0x11112222), (0x8002,0x77778888), (0x8003,0x55556666), (0x0002,1), (0x0001,0). `done_o` rises 12 cycles after start.
- Same setup with random `cfg_ready_i` (≈30% high) → identical write sequence; payload stable on every stalled cycle; `ucode_v_o` low during stalls.
- num_core=3, N=1 → 18 writes; `cfg_core_o` = 0,0,0,0,0,0,1,…,2; `done_o` only after core 2's unfreeze.
- `start_i` pulsed in MODE_UC and in UC_HI → sequence unchanged; `start_i` in DONE → `done_o`=0 and FREEZE write for core 0 next cycle.
- Reset asserted asynchronously while UC_HI is stalled (core 1, entry 1) → all outputs 0 without waiting for a clock edge; restart replays from (core 0, 0x0001,1).
- N=256, ready=1 → last microcode write at addr 0x81FF, `ucode_addr_o` max 255, total 1028 cycles to `done_o`.
